spi_cmd_master: RTL and testbench

- Master-side SPI command generator that drives the peripheral's SPI slave and instruction decoder from the controller side.
- Accepts one register-access request per handshake and serialises a two-byte frame, MSB first, SPI mode 0.
  - Command byte: {wr, hi, addr[5:0]}.
  - Data byte: write data for writes, 0x00 for reads.
- For reads, captures MISO during the data byte and returns it as a one-cycle response.
- Used by top-level test harnesses and any on-chip controller that configures the PWM register file.

---
 rtl/spi_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_spi_cmd_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: serialises {wr, hi, addr[5:0]} + data byte, MSB first, and returns the MISO data byte.
// Define SPI_CS_GAP_EN to add a 2*CLK_DIV-cycle chip-select-high gap after each frame.
module spi_cmd_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic       req_hi,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic       rsp_wr,
    output logic [7:0] rsp_rdata,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  hp_q, hp_d;
    logic [15:0] sr_q, sr_d;
    logic [7:0]  rx_q, rx_d;
    logic        wr_q, wr_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    // The response cycle keeps ready low so chip select is high for at least one cycle.
    assign req_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        hp_d        = hp_q;
        sr_d        = sr_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    sr_d    = {req_wr, req_hi, req_addr, (req_wr ? req_wdata : 8'h00)};
                    wr_d    = req_wr;
                    mosi_d  = req_wr;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = 8'd0;
                    hp_d    = 5'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = !sclk_q;
                    hp_d   = hp_q + 5'd1;
                    if (!sclk_q) begin
                        // Rising edges 8..15 (half-phases 16..30) carry the data byte.
                        if (hp_q[4]) begin
                            rx_d = {rx_q[6:0], miso};
                        end
                    end else if (hp_q != 5'd31) begin
                        sr_d   = {sr_q[14:0], 1'b0};
                        mosi_d = sr_q[14];
                    end
                    if (hp_q == 5'd31) begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d       = 8'd0;
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wr_d    = wr_q;
                    rsp_rdata_d = rx_q;
`ifdef SPI_CS_GAP_EN
                    state_d     = ST_GAP;
`else
                    state_d     = ST_IDLE;
`endif
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
`ifdef SPI_CS_GAP_EN
            ST_GAP: begin
                // Two CLK_DIV-long half-phases with chip select high.
                if (div_q == DIV_LAST) begin
                    div_d = 8'd0;
                    hp_d  = hp_q + 5'd1;
                    if (hp_q[0]) begin
                        hp_d    = 5'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= 8'd0;
            hp_q        <= 5'd0;
            sr_q        <= 16'h0000;
            rx_q        <= 8'h00;
            wr_q        <= 1'b0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hp_q        <= hp_d;
            sr_q        <= sr_d;
            rx_q        <= rx_d;
            wr_q        <= wr_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two instances (CLK_DIV=2 and CLK_DIV=1) checked every cycle against a timeline model.
// Honours SPI_CS_GAP_EN when the design is built with it.
module tb_spi_cmd_master;

    localparam int NI  = 2;
    localparam int BIG = 1000000;
`ifdef SPI_CS_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_r     [NI];
    logic       req_valid_r [NI];
    logic       req_wr_r    [NI];
    logic       req_hi_r    [NI];
    logic [5:0] req_addr_r  [NI];
    logic [7:0] req_wdata_r [NI];
    logic [7:0] rbyte_r     [NI];
    logic       miso_r      [NI];
    logic       req_ready_w [NI];
    logic       rsp_valid_w [NI];
    logic       rsp_wr_w    [NI];
    logic [7:0] rsp_rdata_w [NI];
    logic       sclk_w      [NI];
    logic       cs_n_w      [NI];
    logic       mosi_w      [NI];

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            spi_cmd_master #(.CLK_DIV((gi == 0) ? 2 : 1)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n_r[gi]),
                .req_valid (req_valid_r[gi]),
                .req_ready (req_ready_w[gi]),
                .req_wr    (req_wr_r[gi]),
                .req_hi    (req_hi_r[gi]),
                .req_addr  (req_addr_r[gi]),
                .req_wdata (req_wdata_r[gi]),
                .rsp_valid (rsp_valid_w[gi]),
                .rsp_wr    (rsp_wr_w[gi]),
                .rsp_rdata (rsp_rdata_w[gi]),
                .sclk      (sclk_w[gi]),
                .cs_n      (cs_n_w[gi]),
                .mosi      (mosi_w[gi]),
                .miso      (miso_r[gi])
            );
        end
    endgenerate

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input int k, input string name, input logic [15:0] act, input logic [15:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s[%0d] @%0t got 0x%0h want 0x%0h", name, k, $time, act, exp);
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Model: t = clk cycles since the accepting edge; every output is a function of t and the frame.
    int          t_m       [NI];
    logic [15:0] fw_m      [NI];
    logic [7:0]  rb_m      [NI];
    logic        wr_m      [NI];
    logic [7:0]  exp_rdata [NI];
    logic        exp_wr    [NI];
    // Observed-waveform statistics used for hand-computed expectations.
    int          cyc;
    logic        prev_cs   [NI];
    logic        prev_sclk [NI];
    int          low_cnt   [NI];
    int          rises     [NI];
    logic [15:0] macc      [NI];
    int          rise_cyc  [NI];
    int          last_low  [NI];
    int          last_rises[NI];
    int          last_gap  [NI];
    logic [15:0] last_mosi [NI];
    logic        last_wr   [NI];

    initial begin
        int d, g, t;
        logic e_cs, e_sclk, e_mosi, e_val, e_rdy;
        cyc = 0;
        for (int k = 0; k < NI; k++) begin
            t_m[k] = BIG; fw_m[k] = 16'h0; rb_m[k] = 8'h0; wr_m[k] = 1'b0;
            exp_rdata[k] = 8'h00; exp_wr[k] = 1'b0; miso_r[k] = 1'b0;
            prev_cs[k] = 1'b1; prev_sclk[k] = 1'b0; low_cnt[k] = 0; rises[k] = 0;
            macc[k] = 16'h0; rise_cyc[k] = 0; last_low[k] = 0; last_rises[k] = 0;
            last_gap[k] = 0; last_mosi[k] = 16'h0; last_wr[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) begin
                d = div_of(k);
                g = GAP_EN ? 2 * d : 1;
                if (!rst_n_r[k]) begin
                    t_m[k] = BIG; exp_rdata[k] = 8'h00; exp_wr[k] = 1'b0;
                end
                t = t_m[k];
                if (t == 33 * d) begin
                    exp_rdata[k] = rb_m[k];
                    exp_wr[k]    = wr_m[k];
                end
                e_cs   = !(t < 33 * d);
                e_sclk = (t < 32 * d) ? (((t / d) % 2) == 1) : 1'b0;
                e_mosi = (t < 32 * d) ? fw_m[k][15 - t / (2 * d)] : ((t < 33 * d) ? fw_m[k][0] : 1'b0);
                e_val  = (t == 33 * d);
                e_rdy  = (t >= 33 * d + g);
                chk(k, "cs_n",      16'(cs_n_w[k]),      16'(e_cs));
                chk(k, "sclk",      16'(sclk_w[k]),      16'(e_sclk));
                chk(k, "mosi",      16'(mosi_w[k]),      16'(e_mosi));
                chk(k, "rsp_valid", 16'(rsp_valid_w[k]), 16'(e_val));
                chk(k, "req_ready", 16'(req_ready_w[k]), 16'(e_rdy));
                chk(k, "rsp_rdata", 16'(rsp_rdata_w[k]), 16'(exp_rdata[k]));
                if (e_val) chk(k, "rsp_wr", 16'(rsp_wr_w[k]), 16'(exp_wr[k]));

                if (prev_cs[k] && !cs_n_w[k]) begin
                    last_gap[k] = cyc - rise_cyc[k];
                    low_cnt[k] = 0; rises[k] = 0; macc[k] = 16'h0;
                end
                if (!cs_n_w[k]) low_cnt[k]++;
                if (!cs_n_w[k] && sclk_w[k] && !prev_sclk[k]) begin
                    rises[k]++;
                    macc[k] = {macc[k][14:0], mosi_w[k]};
                end
                if (!prev_cs[k] && cs_n_w[k]) begin
                    rise_cyc[k] = cyc; last_low[k] = low_cnt[k];
                    last_rises[k] = rises[k]; last_mosi[k] = macc[k];
                end
                if (rsp_valid_w[k]) last_wr[k] = rsp_wr_w[k];
                prev_cs[k] = cs_n_w[k];
                prev_sclk[k] = sclk_w[k];

                // Slave model: present data bit (15 - rise index) for rises 8..15, noise otherwise.
                if (t < 32 * d && t / (2 * d) >= 8) miso_r[k] = rb_m[k][15 - t / (2 * d)];
                else miso_r[k] = 1'($urandom);

                if (rst_n_r[k] && e_rdy && req_valid_r[k]) begin
                    fw_m[k] = {req_wr_r[k], req_hi_r[k], req_addr_r[k], (req_wr_r[k] ? req_wdata_r[k] : 8'h00)};
                    rb_m[k] = rbyte_r[k];
                    wr_m[k] = req_wr_r[k];
                    t_m[k]  = 0;
                end else if (t_m[k] < BIG) begin
                    t_m[k]++;
                end
            end
        end
    end

    task automatic send(input int k, input logic wr, input logic hi, input logic [5:0] a,
                        input logic [7:0] wd, input logic [7:0] rb, input bit keep);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #2;
        req_wr_r[k] = wr; req_hi_r[k] = hi; req_addr_r[k] = a;
        req_wdata_r[k] = wd; rbyte_r[k] = rb; req_valid_r[k] = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_w[k];
            @(posedge clk); #2;
        end
        chk(k, "accept", 16'(ok), 16'd1);
        if (!keep) req_valid_r[k] = 1'b0;
        $display("req[%0d] wr=%0d hi=%0d addr=0x%02h wdata=0x%02h miso=0x%02h", k, wr, hi, a, wd, rb);
    endtask

    task automatic wait_rsp(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk); #1;
            seen = rsp_valid_w[k];
        end
        chk(k, "rsp_seen", 16'(seen), 16'd1);
    endtask

    task automatic random_run(input int k, input int n);
        bit keep;
        for (int i = 0; i < n; i++) begin
            keep = (($urandom % 4) == 0) && (i < n - 1);
            send(k, 1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), keep);
            if (!keep) repeat ($urandom % 5) @(posedge clk);
        end
        wait_rsp(k);
    endtask

    initial begin
        bit hit;
        for (int k = 0; k < NI; k++) begin
            rst_n_r[k] = 1'b1; req_valid_r[k] = 1'b0; req_wr_r[k] = 1'b0; req_hi_r[k] = 1'b0;
            req_addr_r[k] = 6'h0; req_wdata_r[k] = 8'h0; rbyte_r[k] = 8'h0;
        end
        #1;
        for (int k = 0; k < NI; k++) rst_n_r[k] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < NI; k++) rst_n_r[k] = 1'b1;

        // Write then a back-to-back read whose address changes while the write is in flight.
        send(0, 1'b1, 1'b1, 6'h05, 8'hA5, 8'h96, 1'b1);
        send(0, 1'b0, 1'b0, 6'h3F, 8'h11, 8'h5A, 1'b0);
        chk(0, "wr_mosi_word", last_mosi[0], 16'hC5A5);
        chk(0, "wr_cs_low", 16'(last_low[0]), 16'd66);
        chk(0, "wr_rises", 16'(last_rises[0]), 16'd16);
        chk(0, "wr_rsp_wr", 16'(last_wr[0]), 16'd1);
        wait_rsp(0);
        chk(0, "b2b_gap", 16'(last_gap[0]), GAP_EN ? 16'd5 : 16'd2);
        chk(0, "busy_mosi_word", last_mosi[0], 16'h3F00);
        chk(0, "busy_rdata", 16'(rsp_rdata_w[0]), 16'h005A);

        send(0, 1'b0, 1'b0, 6'h12, 8'hE7, 8'h3C, 1'b0);
        wait_rsp(0);
        chk(0, "rd_mosi_word", last_mosi[0], 16'h1200);
        chk(0, "rd_rdata", 16'(rsp_rdata_w[0]), 16'h003C);
        chk(0, "rd_rsp_wr", 16'(last_wr[0]), 16'd0);

        // Reset on the ninth sclk rise, then a clean frame.
        send(0, 1'b1, 1'b0, 6'h2A, 8'h99, 8'h77, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk); #1;
            hit = (rises[0] == 9) && !cs_n_w[0];
        end
        chk(0, "reach_rise9", 16'(hit), 16'd1);
        rst_n_r[0] = 1'b0;
        #1;
        chk(0, "rst_cs_n", 16'(cs_n_w[0]), 16'd1);
        chk(0, "rst_sclk", 16'(sclk_w[0]), 16'd0);
        chk(0, "rst_mosi", 16'(mosi_w[0]), 16'd0);
        chk(0, "rst_rsp_valid", 16'(rsp_valid_w[0]), 16'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n_r[0] = 1'b1;
        chk(0, "rst_rdata", 16'(rsp_rdata_w[0]), 16'h0000);
        send(0, 1'b0, 1'b1, 6'h21, 8'h00, 8'hC3, 1'b0);
        wait_rsp(0);
        chk(0, "post_rst_word", last_mosi[0], 16'h6100);
        chk(0, "post_rst_rises", 16'(last_rises[0]), 16'd16);
        chk(0, "post_rst_rdata", 16'(rsp_rdata_w[0]), 16'h00C3);

        random_run(0, 24);

        // CLK_DIV=1 instance.
        send(1, 1'b0, 1'b1, 6'h0A, 8'h55, 8'hFF, 1'b0);
        wait_rsp(1);
        chk(1, "d1_cs_low", 16'(last_low[1]), 16'd33);
        chk(1, "d1_rises", 16'(last_rises[1]), 16'd16);
        chk(1, "d1_mosi_word", last_mosi[1], 16'h4A00);
        chk(1, "d1_rdata", 16'(rsp_rdata_w[1]), 16'h00FF);

        random_run(1, 20);

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout @%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
